// File: rtl/mac_result_serializer.sv
// mac_result_serializer: takes mac_top's flattened C bank in one handshaked read, then streams it one element per cycle.
// Optional build macro MAC_SER_COL_MAJOR_EN switches emission order to column-major.
module mac_result_serializer #(
  parameter int param_M          = 4,
  parameter int param_N          = 4,
  parameter int DATA_WIDTH_FINAL = 16,
  localparam int ROW_W = (param_M > 1) ? $clog2(param_M) : 1,
  localparam int COL_W = (param_N > 1) ? $clog2(param_N) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         mac_block2host_val,
  output logic                                         mac_block2host_rdy,
  output logic                                         mac_c_re,
  input  logic [param_M*param_N*DATA_WIDTH_FINAL-1:0]  mac_c_data_in,
  output logic                                         out_val,
  input  logic                                         out_rdy,
  output logic [DATA_WIDTH_FINAL-1:0]                  out_data,
  output logic [ROW_W-1:0]                             out_row,
  output logic [COL_W-1:0]                             out_col,
  output logic                                         out_last,
  output logic                                         busy,
  output logic                                         frame_done
);

  localparam int NUM_EL = param_M * param_N;
  localparam int CNT_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(param_M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(param_N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_EL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                      state_q;
  logic [DATA_WIDTH_FINAL-1:0] buf_q [NUM_EL];
  logic [CNT_W-1:0]            cnt_q;

  logic [CNT_W-1:0]            cnt_nxt;
  logic [ROW_W-1:0]            row_nxt;
  logic [COL_W-1:0]            col_nxt;
  logic [CNT_W-1:0]            idx_nxt;

  // Position of the element that follows the one currently presented.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    row_nxt = out_row;
    col_nxt = out_col;
    cnt_nxt = cnt_q + 1'b1;
`ifdef MAC_SER_COL_MAJOR_EN
    if (out_row == ROW_LAST) begin
      row_nxt = '0;
      col_nxt = out_col + 1'b1;
    end else begin
      row_nxt = out_row + 1'b1;
    end
`else
    if (out_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = out_row + 1'b1;
    end else begin
      col_nxt = out_col + 1'b1;
    end
`endif
    // Buffer stays row-major in both orders; only the walk differs.
    idx_nxt = CNT_W'(int'(row_nxt) * param_N + int'(col_nxt));
  end

  // NOTE: all state below is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      mac_block2host_rdy <= 1'b0;
      mac_c_re           <= 1'b0;
      out_val            <= 1'b0;
      out_data           <= '0;
      out_row            <= '0;
      out_col            <= '0;
      out_last           <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      // NOTE: the capture buffer is small and register-based, so clearing it on reset is cheap and intended.
      for (int i = 0; i < NUM_EL; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_done <= 1'b0;
          if (mac_block2host_val) begin
            state_q            <= S_READ;
            mac_block2host_rdy <= 1'b1;
            mac_c_re           <= 1'b1;
            busy               <= 1'b1;
          end
        end

        S_READ: begin
          mac_block2host_rdy <= 1'b0;
          mac_c_re           <= 1'b0;
          state_q            <= S_CAPTURE;
        end

        // mac_top read data is valid one cycle after c_re.
        S_CAPTURE: begin
          for (int i = 0; i < NUM_EL; i++) begin
            buf_q[i] <= mac_c_data_in[i*DATA_WIDTH_FINAL +: DATA_WIDTH_FINAL];
          end
          cnt_q    <= '0;
          out_val  <= 1'b1;
          out_data <= mac_c_data_in[DATA_WIDTH_FINAL-1:0];
          out_row  <= '0;
          out_col  <= '0;
          out_last <= (NUM_EL == 1);
          state_q  <= S_STREAM;
        end

        S_STREAM: begin
          if (out_rdy) begin
            if (out_last) begin
              out_val    <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              cnt_q    <= cnt_nxt;
              out_row  <= row_nxt;
              out_col  <= col_nxt;
              out_data <= buf_q[idx_nxt];
              out_last <= (cnt_nxt == CNT_LAST);
            end
          end
        end

        S_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
